// File: rtl/mem_stage.sv
// Memory stage: splits each 32-bit load/store into two 16-bit SRAM accesses
// (low halfword first) and holds ready low until the pair has completed.
module mem_stage #(
   parameter int unsigned BIT_NUMBER  = 32,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BIT_NUMBER-1:0] pc_in,
   input  logic [BIT_NUMBER-1:0] instruction_in,
   input  logic                  mem_r_en,
   input  logic                  mem_w_en,
   input  logic [BIT_NUMBER-1:0] alu_result,
   input  logic [BIT_NUMBER-1:0] val_rm,
   output logic [BIT_NUMBER-1:0] pc,
   output logic [BIT_NUMBER-1:0] instruction,
   output logic [BIT_NUMBER-1:0] mem_read_value,
   output logic                  ready,
   output logic [17:0]           sram_addr,
   output logic [15:0]           sram_dq_out,
   output logic                  sram_dq_oe,
   input  logic [15:0]           sram_dq_in,
   output logic                  sram_we_n
);

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned HALF_W  = 16;
   localparam int unsigned SRAM_AW = 18;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BIT_NUMBER-1:0] rdata_q, rdata_d;
   logic                  req_c, store_c, load_c, last_c, active_c;
   logic                  unused_c;

   // Both enables high resolves to a store.
   assign req_c    = mem_r_en | mem_w_en;
   assign store_c  = mem_w_en;
   assign load_c   = mem_r_en & ~mem_w_en;
   assign last_c   = (cnt_q == LAST_CNT);
   assign active_c = (state_q == LOW) || (state_q == HIGH);
   assign unused_c = ^{alu_result[BIT_NUMBER-1:SRAM_AW+1], alu_result[1:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   // Phase sequencing; the load halves are captured on the last edge of each phase.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (req_c) state_d = LOW;
         end
         LOW: begin
            if (last_c) begin
               state_d = HIGH;
               cnt_d   = '0;
               if (load_c) rdata_d[HALF_W-1:0] = sram_dq_in;
            end
         end
         HIGH: begin
            if (last_c) begin
               state_d = DONE;
               cnt_d   = '0;
               if (load_c) rdata_d[2*HALF_W-1:HALF_W] = sram_dq_in;
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      sram_addr   = {alu_result[SRAM_AW:2], 1'b0};
      sram_dq_out = val_rm[HALF_W-1:0];
      sram_we_n   = 1'b1;
      sram_dq_oe  = 1'b0;
      ready       = 1'b0;
      if (state_q == HIGH) begin
         sram_addr   = {alu_result[SRAM_AW:2], 1'b1};
         sram_dq_out = val_rm[2*HALF_W-1:HALF_W];
      end
      if (active_c && store_c) begin
         sram_we_n  = 1'b0;
         sram_dq_oe = 1'b1;
      end
      if (((state_q == IDLE) && !req_c) || (state_q == DONE)) ready = 1'b1;
   end

   assign pc             = pc_in;
   assign instruction    = instruction_in;
   assign mem_read_value = rdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage with WAIT_CYCLES=2 against a behavioural 16-bit SRAM.
module tb_mem_stage;

   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  pc_in, instruction_in, alu_result, val_rm;
   logic          mem_r_en, mem_w_en;
   logic [W-1:0]  pc, instruction, mem_read_value;
   logic          ready;
   logic [17:0]   sram_addr;
   logic [15:0]   sram_dq_out, sram_dq_in;
   logic          sram_dq_oe, sram_we_n;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic [31:0] exp_q[$];

   logic [15:0] sram [0:(1<<18)-1];

   mem_stage #(.BIT_NUMBER(W), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .instruction_in(instruction_in),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .alu_result(alu_result),
      .val_rm(val_rm), .pc(pc), .instruction(instruction),
      .mem_read_value(mem_read_value), .ready(ready), .sram_addr(sram_addr),
      .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (!sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;
   assign sram_dq_in = sram[sram_addr];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } idle_vec_t;

   typedef struct {
      logic        r;
      logic        w;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      int          exp_we;
   } txn_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one request from IDLE and returns at the sample point of its ready cycle.
   task automatic access(input logic r, input logic w, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         output int ready_rel, output int ready_abs, output int we_cnt);
      logic [31:0] exp;
      mem_r_en = r; mem_w_en = w; alu_result = addr; val_rm = wdata;
      exp_q.push_back(exp_rd);
      ready_rel = -1; ready_abs = -1; we_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (c == 1) check("addr_low", 32'(sram_addr), 32'({addr[18:2], 1'b0}));
         if (c == 3) check("addr_high", 32'(sram_addr), 32'({addr[18:2], 1'b1}));
         if (!sram_we_n) we_cnt++;
         if (ready) begin
            ready_rel = c;
            ready_abs = cyc;
            break;
         end
         @(posedge clk);
         #1;
      end
      exp = exp_q.pop_front();
      if (ready_rel < 0) check("ready_timeout", 32'(0), 32'(1));
      else check("read_value", mem_read_value, exp);
   endtask

   idle_vec_t ivec[4];
   txn_t      txns[6];
   int        rel, abs1, abs2, wec, rel_start;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      ivec[0] = '{32'h0000_0004, 32'hE3A0_1001};
      ivec[1] = '{32'hFFFF_FFFC, 32'h0000_0000};
      ivec[2] = '{32'h1234_5678, 32'hFFFF_FFFF};
      ivec[3] = '{32'h0000_0000, 32'hA5A5_5A5A};

      txns[0] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,          32'hABCD_1234, 0};
      txns[1] = '{1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'hABCD_1234, 4};
      txns[2] = '{1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'hABCD_1234, 4};
      txns[3] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,          32'hDEAD_BEEF, 0};
      txns[4] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          32'hCAFE_F00D, 0};
      txns[5] = '{1'b1, 1'b0, 32'h0000_0403, 32'h0,          32'hABCD_1234, 0};

      // Byte address 0x400 maps to the halfword pair 0x200/0x201.
      sram[18'h200] = 16'h1234;
      sram[18'h201] = 16'hABCD;

      rst = 1'b0;
      pc_in = '0; instruction_in = '0; alu_result = '0; val_rm = '0;
      mem_r_en = 1'b0; mem_w_en = 1'b0;
      #2;
      check("reset_read_value", mem_read_value, 32'h0);
      check("reset_we_n", 32'(sram_we_n), 32'(1));
      check("reset_oe", 32'(sram_dq_oe), 32'(0));
      check("reset_ready", 32'(ready), 32'(1));
      @(negedge clk);
      rst = 1'b1;
      step();

      for (int i = 0; i < 4; i++) begin
         pc_in = ivec[i].pc;
         instruction_in = ivec[i].instr;
         #1;
         check("fwd_pc", pc, ivec[i].pc);
         check("fwd_instr", instruction, ivec[i].instr);
         check("idle_ready", 32'(ready), 32'(1));
         step();
      end

      for (int i = 0; i < 6; i++) begin
         access(txns[i].r, txns[i].w, txns[i].addr, txns[i].wdata, txns[i].exp_rd,
                rel, abs1, wec);
         check("ready_cycle", 32'(rel), 32'(5));
         check("we_cycles", 32'(wec), 32'(txns[i].exp_we));
         step();
         mem_r_en = 1'b0; mem_w_en = 1'b0;
         #1;
         check("post_ready", 32'(ready), 32'(1));
         check("hold_read_value", mem_read_value, txns[i].exp_rd);
         step();
      end
      check("sram_4", 32'(sram[18'h4]), 32'h0000_BEEF);
      check("sram_5", 32'(sram[18'h5]), 32'h0000_DEAD);
      check("sram_8", 32'(sram[18'h8]), 32'h0000_F00D);
      check("sram_9", 32'(sram[18'h9]), 32'h0000_CAFE);

      // Reset asserted during the HIGH phase of a load.
      mem_r_en = 1'b1; alu_result = 32'h0000_0400;
      repeat (3) step();
      #2 rst = 1'b0;
      #1;
      check("midrst_read_value", mem_read_value, 32'h0);
      check("midrst_we_n", 32'(sram_we_n), 32'(1));
      check("midrst_oe", 32'(sram_dq_oe), 32'(0));
      check("midrst_ready", 32'(ready), 32'(0));
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      rel_start = cyc;
      exp_q.push_back(32'hABCD_1234);
      abs1 = -1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (ready) begin
            abs1 = cyc;
            break;
         end
      end
      check("restart_latency", 32'(abs1 - rel_start), 32'(5));
      check("restart_read_value", mem_read_value, exp_q.pop_front());
      step();
      mem_r_en = 1'b0;
      step();

      // Store then load to the same word with no idle gap.
      access(1'b0, 1'b1, 32'h0000_0020, 32'h1357_9BDF, 32'hABCD_1234, rel, abs1, wec);
      check("b2b_store_we", 32'(wec), 32'(4));
      step();
      access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h1357_9BDF, rel, abs2, wec);
      check("b2b_ready_gap", 32'(abs2 - abs1), 32'(6));
      step();
      mem_r_en = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
